// File: rtl/serial_pkg.sv
// serial_pkg: types and constants shared by the serial agent rx deframer and tx framer.
package serial_pkg;

    // Receive FSM state encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Level of an idle serial line; also the preset value of the synchronizers.
    localparam logic SERIAL_IDLE_LVL = 1'b1;

endpackage

// File: rtl/serial_sync.sv
// serial_sync: STAGES-deep flop chain bringing an asynchronous serial line into clk.
// The chain is preset to the idle line level so that reset release never looks like
// a start bit.
module serial_sync
    import serial_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw line through the chain; preset to idle on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{SERIAL_IDLE_LVL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/serial_rx_deframer.sv
// serial_rx_deframer: receive side of the serial agent link.
// Recovers idle-high, start(0) / DATA_W bits LSB first / stop(1) frames by mid-bit
// sampling and presents each byte on a valid/ready port.
// Optional feature macro: SERIAL_RX_PARITY_EN adds an even-parity bit after the data
// bits and a parity_err output.
//
// Handshake: rx_valid rises with rx_data stable and stays high, with rx_data unchanged,
// until a cycle where rx_valid & rx_ready are both 1; that cycle is the transfer.
// A frame completing while the slot is still full (and not being accepted in that
// same cycle) is dropped with a one-cycle overrun pulse.
module serial_rx_deframer
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
`ifdef SERIAL_RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy,
    output logic [2:0]        state_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = PARITY;
`endif
    localparam logic [2:0] ST_STOP   = STOP;
    localparam logic [2:0] ST_BREAK  = BREAK;

    logic              line;
    logic [2:0]        state;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              commit_pend;
`ifdef SERIAL_RX_PARITY_EN
    logic              par_bad;
`endif

    serial_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_rx),
        .q   (line)
    );

    // Frame FSM: start detection, mid-bit sampling, stop check and break recovery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            commit_pend <= 1'b0;
            frame_err   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad     <= 1'b0;
`endif
        end else begin
            commit_pend <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!line) begin
                        state   <= ST_START;
                        clk_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        // A line back high at mid start bit was only a glitch.
                        state   <= line ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        // LSB arrives first, so shifting in from the top lands it at bit 0.
                        shreg   <= {line, shreg[DATA_W-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            state   <= ST_PARITY;
`else
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        par_bad <= (^shreg) ^ line;
                        state   <= ST_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        if (line) begin
                            commit_pend <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            frame_err   <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Hold here while the line stays low so a break reports only once.
                    if (line) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output slot: load a committed byte, drop it on overrun, clear on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (commit_pend) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    rx_valid   <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    parity_err <= par_bad;
`endif
                end else begin
                    overrun    <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_rx_deframer.sv
// tb_serial_rx_deframer: directed tests for serial_rx_deframer
// (DATA_W=8, CLKS_PER_BIT=16, SYNC_STAGES=2). Define SERIAL_RX_PARITY_EN to also
// exercise the parity build.
module tb_serial_rx_deframer;

    localparam int DATA_W = 8;
    localparam int CPB    = 16;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              serial_rx = 1'b1;
    logic              rx_ready = 1'b0;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              overrun;
    logic              busy;
    logic [2:0]        state_dbg;
`ifdef SERIAL_RX_PARITY_EN
    logic              parity_err;
    logic              par_flip = 1'b0;
    int                pe_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] acc_q[$];
    int fe_cnt, ov_cnt, valid_cyc, busy_cyc;
    int cyc = 0;
    int rise_cyc;
    int stop_edge;
    logic valid_d = 1'b0;

    serial_rx_deframer #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_rx  (serial_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: collect accepted bytes and count pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
`ifdef SERIAL_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            if (rx_valid) valid_cyc++;
            if (busy) busy_cyc++;
            if (rx_valid && !valid_d) rise_cyc = cyc;
        end
        valid_d = rx_valid;
    end

    task clear_mon();
        fe_cnt = 0; ov_cnt = 0; valid_cyc = 0; busy_cyc = 0; rise_cyc = -1;
`ifdef SERIAL_RX_PARITY_EN
        pe_cnt = 0;
`endif
        acc_q.delete();
        exp_q.delete();
    endtask

    // Driver: each call starts 1 ns after a rising edge and holds one bit time.
    task drive_bit(input logic b);
        serial_rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task idle(input int n);
        serial_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        stop_edge = cyc + 1;
        drive_bit(stop_b);
    endtask

    task test_reset();
        repeat (3) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
    endtask

    task test_single_a5();
        logic [7:0] e;
        clear_mon();
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(CPB);
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL a5_count: got %0d expected 1", acc_q.size()); end
        else begin
            e = exp_q.pop_front();
            checks++; if (acc_q[0] !== e) begin errors++; $display("FAIL a5_data: got %h expected %h", acc_q[0], e); end
        end
        checks++; if (valid_cyc != 1) begin errors++; $display("FAIL a5_valid_cycles: got %0d expected 1", valid_cyc); end
        checks++; if (rise_cyc - stop_edge != 11) begin errors++; $display("FAIL a5_latency: got %0d expected 11", rise_cyc - stop_edge); end
        checks++; if (fe_cnt != 0 || ov_cnt != 0) begin errors++; $display("FAIL a5_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy: got %b expected 0", busy); end
    endtask

    task test_back_to_back();
        logic [7:0] pats [4];
        logic [7:0] e;
        pats = '{8'h00, 8'hFF, 8'h5A, 8'h81};
        clear_mon();
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pats[i]);
            send_frame(pats[i], 1'b1);
        end
        idle(CPB);
        checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", acc_q.size()); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            if (acc_q.size() > 0) begin
                checks++; if (acc_q[0] !== e) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, acc_q[0], e); end
                void'(acc_q.pop_front());
            end
        end
        checks++; if (fe_cnt != 0 || ov_cnt != 0) begin errors++; $display("FAIL b2b_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt); end
    endtask

    task test_glitch();
        clear_mon();
        serial_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(3 * CPB);
        checks++; if (busy_cyc != 8) begin errors++; $display("FAIL glitch_busy_cycles: got %0d expected 8", busy_cyc); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL glitch_state: got %0d expected 0", state_dbg); end
        checks++; if (valid_cyc != 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", valid_cyc); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt); end
    endtask

    task test_frame_err();
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0);
        idle(CPB);
        checks++; if (fe_cnt != 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt); end
        checks++; if (valid_cyc != 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", valid_cyc); end
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        idle(CPB);
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL ferr_next_count: got %0d expected 1", acc_q.size()); end
        else begin
            checks++; if (acc_q[0] !== exp_q[0]) begin errors++; $display("FAIL ferr_next_data: got %h expected %h", acc_q[0], exp_q[0]); end
        end
        checks++; if (fe_cnt != 1 || ov_cnt != 0) begin errors++; $display("FAIL ferr_flags_after: got fe=%0d ov=%0d expected 1 0", fe_cnt, ov_cnt); end
    endtask

    task test_overrun();
        clear_mon();
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(CPB);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_held: got %h expected 11", rx_data); end
        checks++; if (ov_cnt != 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt); end
        rx_ready = 1'b1;
        idle(4);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b expected 0", rx_valid); end
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", acc_q.size()); end
        else begin
            checks++; if (acc_q[0] !== exp_q[0]) begin errors++; $display("FAIL ovr_data: got %h expected %h", acc_q[0], exp_q[0]); end
        end
    endtask

    task test_rst_mid_frame();
        clear_mon();
        rx_ready = 1'b1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst = 1'b1;
        serial_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_in_reset: got %b expected 0", busy); end
        rst = 1'b0;
        idle(2 * CPB);
        checks++; if (fe_cnt != 0 || ov_cnt != 0 || valid_cyc != 0) begin errors++; $display("FAIL rstmid_no_flags: got fe=%0d ov=%0d valid=%0d expected 0 0 0", fe_cnt, ov_cnt, valid_cyc); end
        exp_q.push_back(8'h66);
        send_frame(8'h66, 1'b1);
        idle(CPB);
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", acc_q.size()); end
        else begin
            checks++; if (acc_q[0] !== exp_q[0]) begin errors++; $display("FAIL rstmid_data: got %h expected %h", acc_q[0], exp_q[0]); end
        end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task test_parity();
        clear_mon();
        rx_ready = 1'b1;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(CPB);
        par_flip = 1'b0;
        checks++; if (pe_cnt != 1) begin errors++; $display("FAIL par_bad_pulse: got %0d expected 1", pe_cnt); end
        checks++; if (acc_q.size() != 1 || acc_q[0] !== 8'h07) begin errors++; $display("FAIL par_bad_delivered: got %0d bytes expected one 07", acc_q.size()); end
        send_frame(8'h07, 1'b1);
        idle(CPB);
        checks++; if (pe_cnt != 1) begin errors++; $display("FAIL par_good_no_pulse: got %0d expected 1", pe_cnt); end
        checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL par_good_count: got %0d expected 2", acc_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_rst_mid_frame();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
